fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FWFT queue of fetch packets between the fetch stage and the decode register
module fetch_buffer #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h03400000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fb_flush,
    input  logic        if_readygo,
    output logic        fb_allowin,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_next,
    input  logic [31:0] if_badv,
    input  logic [6:0]  if_exception,
    input  logic [1:0]  if_excp_flag,
    output logic        fifo_readygo,
    input  logic        fifo_allowin,
    output logic [31:0] fifo_inst0,
    output logic [31:0] fifo_inst1,
    output logic [31:0] fifo_pc,
    output logic [31:0] fifo_pc_next,
    output logic [31:0] fifo_pcAdd,
    output logic [31:0] fifo_badv,
    output logic [6:0]  fifo_exception,
    output logic [1:0]  fifo_excp_flag,
    output logic        fetch_buf_empty,
    output logic        fetch_buf_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    typedef struct packed {
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        h;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          push, pop;

    assign fetch_buf_empty = count == '0;
    assign fetch_buf_full  = count == (AW+1)'(DEPTH);
    assign fb_allowin      = !fetch_buf_full;
    assign fifo_readygo    = !fetch_buf_empty;
    assign push            = if_readygo && fb_allowin;
    assign pop             = fifo_readygo && fifo_allowin;

    // pointers wrap for free since DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fb_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !fb_flush)
            mem[tail] <= '{if_inst0, if_inst1, if_pc, if_pc_next, if_badv, if_exception, if_excp_flag};
    end

    assign h = mem[head];

    always_comb begin
        fifo_inst0     = fetch_buf_empty ? NOP : h.inst0;
        fifo_inst1     = fetch_buf_empty ? NOP : h.inst1;
        fifo_pc        = fetch_buf_empty ? RESET_PC : h.pc;
        fifo_pc_next   = fetch_buf_empty ? RESET_PC + 32'd8 : h.pc_next;
        fifo_badv      = fetch_buf_empty ? RESET_PC : h.badv;
        fifo_exception = fetch_buf_empty ? 7'd0 : h.exception;
        fifo_excp_flag = fetch_buf_empty ? 2'd0 : h.excp_flag;
        fifo_pcAdd     = fifo_pc + 32'd4;
    end
endmodule
